// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_op codes and FSM state encoding shared by the mul/div unit and stall control
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd3;
  localparam logic [3:0] MD_MULTU = 4'd4;
  localparam logic [3:0] MD_DIV   = 4'd8;
  localparam logic [3:0] MD_DIVU  = 4'd9;
  localparam logic [3:0] MD_MTHI  = 4'd10;
  localparam logic [3:0] MD_MTLO  = 4'd11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for multiple cycles
  function automatic logic is_mul_div(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

  md_state_e      state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [31:0]    hi_q, lo_q;
  logic [31:0]    pend_hi_q, pend_lo_q;
  logic           pend_wr_q;

  logic           accept;
  logic           run_d;
  logic           wr_d;
  logic [CW-1:0]  lat_d;
  logic [63:0]    res_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic        [31:0] dvs_u, quo_u, rem_u;

  assign accept = start & ~req & (state_q == S_IDLE);

  // Signed divide is done at 33 bits so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000
  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'b0, rs} * {32'b0, rt};
    dvd_s  = $signed({rs[31], rs});
    dvs_s  = (rt == 32'd0) ? 33'sd1 : $signed({rt[31], rt});
    quo_s  = dvd_s / dvs_s;
    rem_s  = dvd_s % dvs_s;
    dvs_u  = (rt == 32'd0) ? 32'd1 : rt;
    quo_u  = rs / dvs_u;
    rem_u  = rs % dvs_u;
  end

  always_comb begin
    run_d = is_mul_div(md_op);
    wr_d  = 1'b0;
    lat_d = '0;
    res_d = '0;
    case (md_op)
      MD_MULT:  begin res_d = prod_s;                        wr_d = 1'b1; lat_d = MUL_LAT; end
      MD_MULTU: begin res_d = prod_u;                        wr_d = 1'b1; lat_d = MUL_LAT; end
      MD_DIV:   begin res_d = {32'(rem_s), 32'(quo_s)};      wr_d = |rt;  lat_d = DIV_LAT; end
      MD_DIVU:  begin res_d = {rem_u, quo_u};                wr_d = |rt;  lat_d = DIV_LAT; end
      default:  begin res_d = '0;                            wr_d = 1'b0; lat_d = '0;      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (run_d) begin
              pend_hi_q <= res_d[63:32];
              pend_lo_q <= res_d[31:0];
              pend_wr_q <= wr_d;
              cnt_q     <= lat_d;
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
            end else if (md_op == MD_MTHI) begin
              hi_q <= rs;
            end else if (md_op == MD_MTLO) begin
              lo_q <= rs;
            end
          end
        end
        S_RUN: begin
          // Result is architecturally committed; req cannot cancel it
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomized checks of mul_div_unit against an arithmetic HI/LO model
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [3:0]  md_op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs(rs), .rt(rt), .req(req), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op);
    if (op == MD_MULT || op == MD_MULTU) return 5;
    if (op == MD_DIV  || op == MD_DIVU)  return 10;
    return 0;
  endfunction

  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      MD_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default:  ;
    endcase
  endtask

  // Called at a negedge; returns at the first negedge with busy low so the next op issues in that cycle
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic blk, input int inj_at, input logic inj_req, input string tag);
    int n;
    logic held;
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; held = 1'b1;
    start = 1'b1; md_op = op; rs = a; rt = b; req = blk;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (n == inj_at) begin
        start = 1'b1; md_op = MD_MTHI; rs = 32'hDEAD_BEEF; req = inj_req;
      end else begin
        start = 1'b0; req = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; req = 1'b0;
    if (!blk) model_apply(op, a, b);
    check($sformatf("%s_busy_cycles", tag), 64'(n), 64'(blk ? 0 : exp_lat(op)));
    check($sformatf("%s_hold", tag), {63'b0, held}, 64'd1);
    check($sformatf("%s_hi", tag), {32'b0, hi}, {32'b0, m_hi});
    check($sformatf("%s_lo", tag), {32'b0, lo}, {32'b0, m_lo});
  endtask

  logic [3:0]  ops [7];
  logic [31:0] ra, rb;
  logic [3:0]  rop;

  initial begin
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, 4'd5};
    reset = 1'b1; start = 1'b0; req = 1'b0; md_op = '0; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);

    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0, "mult_m3x7");
    check("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0, "multu");
    check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0, "div_m7d2");
    check("div_m7d2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MD_DIVU, 32'd1234, 32'd0, 1'b0, 0, 1'b0, "divu_by0");
    check("divu_by0_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    do_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, 0, 1'b0, "mthi");
    do_op(MD_MTLO, 32'h5678, 32'd0, 1'b0, 0, 1'b0, "mtlo");
    check("mt_const", {hi, lo}, 64'h0000_1234_0000_5678);

    do_op(MD_MULT, 32'd6, 32'd7, 1'b0, 2, 1'b0, "mthi_while_busy");
    check("mthi_while_busy_const", {hi, lo}, 64'd42);
    do_op(MD_MTLO, 32'hAAAA, 32'd0, 1'b1, 0, 1'b0, "req_blocks_mtlo");
    do_op(MD_MULT, 32'd9, 32'd9, 1'b1, 0, 1'b0, "req_blocks_mult");
    do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 3, 1'b1, "req_mid_mult");
    check("req_mid_mult_const", {hi, lo}, 64'h0000_0001_0000_0000);
    do_op(4'd5, 32'h7777, 32'h3, 1'b0, 0, 1'b0, "unknown_op");

    start = 1'b1; md_op = MD_DIV; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("prereset_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midrun_reset_busy", {63'b0, busy}, 64'd0);
    check("midrun_reset_hilo", {hi, lo}, 64'd0);
    do_op(MD_MULTU, 32'd11, 32'd13, 1'b0, 0, 1'b0, "post_reset_multu");

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 6)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      do_op(rop, ra, rb, 1'b0, 0, 1'b0, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
